// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed hex driver for a common-anode 7-segment display
// Double-buffered digit data is committed only at the frame wrap so the scan never tears.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   en_in,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d, sh_en_q, sh_en_d;
  logic                    pending_q, pending_d;
  logic                    frame_start_q, frame_start_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    tick, wrap, nz_seen, lz_hide;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0001100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    act_val_d     = act_val_q;
    act_dp_d      = act_dp_q;
    act_en_d      = act_en_q;
    sh_val_d      = sh_val_q;
    sh_dp_d       = sh_dp_q;
    sh_en_d       = sh_en_q;
    pending_d     = pending_q;
    frame_start_d = 1'b0;
    an_d          = '1;
    seg_d         = 7'h7F;
    dp_d          = 1'b1;
    nz_seen       = 1'b0;
    lz_hide       = 1'b0;

    tick  = (cnt_q == CNT_MAX);
    wrap  = tick && (idx_q == IDX_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    if (tick) idx_d = wrap ? '0 : idx_q + 1'b1;

    // Commit reads the old shadow before a coincident load overwrites it.
    if (wrap) begin
      frame_start_d = 1'b1;
      if (pending_q) begin
        act_val_d = sh_val_q;
        act_dp_d  = sh_dp_q;
        act_en_d  = sh_en_q;
        pending_d = 1'b0;
      end
    end
    if (load) begin
      sh_val_d  = value_in;
      sh_dp_d   = dp_in;
      sh_en_d   = en_in;
      pending_d = 1'b1;
    end

    // Walk from the most significant digit down so nz_seen covers all digits j>=i.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_seen = nz_seen | (act_val_q[4*i +: 4] != 4'h0);
      lz_hide = (LZ_BLANK != 0) && (i != 0) && !nz_seen;
      if ((idx_q == IDX_W'(i)) && act_en_q[i] && !lz_hide) begin
        an_d[i] = 1'b0;
        seg_d   = decode(act_val_q[4*i +: 4]);
        dp_d    = ~act_dp_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      act_val_q     <= '0;
      act_dp_q      <= '0;
      act_en_q      <= '0;
      sh_val_q      <= '0;
      sh_dp_q       <= '0;
      sh_en_q       <= '0;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      an_q          <= '1;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      act_val_q     <= act_val_d;
      act_dp_q      <= act_dp_d;
      act_en_q      <= act_en_d;
      sh_val_q      <= sh_val_d;
      sh_dp_q       <= sh_dp_d;
      sh_en_q       <= sh_en_d;
      pending_q     <= pending_d;
      frame_start_q <= frame_start_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign pending     = pending_q;
  assign frame_start = frame_start_q;
  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - bench for seven_seg_scan_driver (4 digits, divide-by-4)
// Two instances (LZ_BLANK=0 and 1) share stimulus and are compared against a time-indexed model.
module tb_seven_seg_scan_driver;

  localparam int N = 4;
  localparam int R = 4;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0] nib;
    logic [6:0] seg;
  } dec_vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   value_in;
  logic [3:0]    dp_in, en_in;
  logic          load;
  logic          pend0, fs0, dp0, pend1, fs1, dp1;
  logic [3:0]    an0, an1;
  logic [6:0]    seg0, seg1;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: time since reset determines the scan position
  int          m_t;
  logic [15:0] m_act_val, m_sh_val;
  logic [3:0]  m_act_dp, m_act_en, m_sh_dp, m_sh_en;
  logic        m_pend, m_fs;
  logic [3:0]  e_an [2];
  logic [6:0]  e_seg [2];
  logic        e_dp [2];

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .LZ_BLANK(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .pending(pend0), .frame_start(fs0), .an(an0), .seg(seg0), .dp(dp0));

  seven_seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .LZ_BLANK(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .value_in(value_in), .dp_in(dp_in), .en_in(en_in),
    .load(load), .pending(pend1), .frame_start(fs1), .an(an1), .seg(seg1), .dp(dp1));

  task automatic model_out(input int lz, input int d, output logic [3:0] a_o,
                           output logic [6:0] s_o, output logic d_o);
    bit zero_above = 1'b1;
    for (int j = d; j < N; j++) if (m_act_val[4*j +: 4] != 4'h0) zero_above = 1'b0;
    a_o = 4'hF;
    s_o = 7'h7F;
    d_o = 1'b1;
    if (m_act_en[d] && !(lz != 0 && d != 0 && zero_above)) begin
      a_o[d] = 1'b0;
      s_o    = SEG_LUT[m_act_val[4*d +: 4]];
      d_o    = ~m_act_dp[d];
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_t = 0;
      m_act_val = '0; m_act_dp = '0; m_act_en = '0;
      m_sh_val = '0;  m_sh_dp = '0;  m_sh_en = '0;
      m_pend = 1'b0;  m_fs = 1'b0;
      for (int k = 0; k < 2; k++) begin
        e_an[k] = 4'hF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_out(k, (m_t / R) % N, e_an[k], e_seg[k], e_dp[k]);
      m_fs = (m_t % (R * N)) == (R * N - 1);
      if (m_fs && m_pend) begin
        m_act_val = m_sh_val; m_act_dp = m_sh_dp; m_act_en = m_sh_en;
        m_pend = 1'b0;
      end
      if (load) begin
        m_sh_val = value_in; m_sh_dp = dp_in; m_sh_en = en_in;
        m_pend = 1'b1;
      end
      m_t++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("model_an0", an0, e_an[0]);
    chk("model_seg0", seg0, e_seg[0]);
    chk("model_dp0", dp0, e_dp[0]);
    chk("model_an1", an1, e_an[1]);
    chk("model_seg1", seg1, e_seg[1]);
    chk("model_dp1", dp1, e_dp[1]);
    chk("model_pending", {pend1, pend0}, {m_pend, m_pend});
    chk("model_frame_start", {fs1, fs0}, {m_fs, m_fs});
  endtask

  task automatic wait_fs();
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (fs0) found = 1'b1;
    end
    chk("frame_start_seen", found, 1'b1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] e, input logic [3:0] d);
    value_in = v; en_in = e; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_frame(input bit use_lz, input string tag, input logic [15:0] an_e,
                             input logic [27:0] seg_e, input logic [3:0] dp_e);
    wait_fs();
    chk({tag, "_pending_at_fs"}, pend0, 1'b0);
    for (int d = 0; d < N; d++) begin
      repeat (d == 0 ? 1 : 4) step();
      chk({tag, "_an"}, use_lz ? an1 : an0, an_e[4*d +: 4]);
      chk({tag, "_seg"}, use_lz ? seg1 : seg0, seg_e[7*d +: 7]);
      chk({tag, "_dp"}, use_lz ? dp1 : dp0, dp_e[d]);
    end
  endtask

  initial begin
    dec_vec_t vecs [16];
    for (int i = 0; i < 16; i++) vecs[i].nib = 4'(i);
    vecs[0].seg  = 7'b0000001; vecs[1].seg  = 7'b1001111; vecs[2].seg  = 7'b0010010;
    vecs[3].seg  = 7'b0000110; vecs[4].seg  = 7'b1001100; vecs[5].seg  = 7'b0100100;
    vecs[6].seg  = 7'b0100000; vecs[7].seg  = 7'b0001111; vecs[8].seg  = 7'b0000000;
    vecs[9].seg  = 7'b0001100; vecs[10].seg = 7'b0001000; vecs[11].seg = 7'b1100000;
    vecs[12].seg = 7'b0110001; vecs[13].seg = 7'b1000010; vecs[14].seg = 7'b0110000;
    vecs[15].seg = 7'b0111000;

    reset_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; en_in = '0;
    repeat (3) step();
    chk("reset_an", an0, 4'hF);
    chk("reset_seg", seg0, 7'h7F);
    chk("reset_dp", dp0, 1'b1);
    chk("reset_pending", pend0, 1'b0);
    reset_n = 1'b1;
    repeat (20) step();
    chk("idle_blank_an", {an1, an0}, 8'hFF);

    // basic display with decimal point on digit 2
    do_load(16'h1A3F, 4'hF, 4'b0100);
    chk("load_pending", pend0, 1'b1);
    check_frame(1'b0, "basic", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1001111, 7'b0001000, 7'b0000110, 7'b0111000}, 4'b1011);

    // mid-frame load does not tear the current frame
    wait_fs();
    repeat (5) step();
    do_load(16'h2222, 4'hF, 4'b0000);
    chk("midframe_pending", pend0, 1'b1);
    repeat (3) step();
    chk("midframe_d2_old", seg0, 7'b0001000);
    repeat (4) step();
    chk("midframe_d3_old", seg0, 7'b1001111);
    check_frame(1'b0, "newframe", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {4{7'b0010010}}, 4'b1111);

    // leading-zero blanking
    do_load(16'h0050, 4'hF, 4'b1100);
    check_frame(1'b1, "lz0050", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'b0100100, 7'b0000001}, 4'b1111);
    do_load(16'h0000, 4'hF, 4'b0000);
    check_frame(1'b1, "lz0000", {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'h7F, 7'h7F, 7'h7F, 7'b0000001}, 4'b1111);

    // two loads in a frame: last wins
    do_load(16'h1111, 4'hF, 4'b0000);
    do_load(16'h9999, 4'hF, 4'b0000);
    check_frame(1'b0, "lastwins", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {4{7'b0001100}}, 4'b1111);

    // load coinciding with the commit edge keeps pending
    do_load(16'h4444, 4'hF, 4'b0000);
    for (int i = 0; i < 20 && (m_t % (R * N)) != (R * N - 1); i++) step();
    do_load(16'h7777, 4'hF, 4'b0000);
    chk("commit_edge_fs", fs0, 1'b1);
    chk("commit_edge_pending", pend0, 1'b1);
    check_frame(1'b0, "commitedge", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {4{7'b0001111}}, 4'b1111);

    // reset mid-scan discards a pending load
    wait_fs();
    do_load(16'h8888, 4'hF, 4'hF);
    repeat (8) step();
    chk("pre_reset_pending", pend0, 1'b1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("midreset_an", an0, 4'hF);
    chk("midreset_seg", seg0, 7'h7F);
    chk("midreset_dp", dp0, 1'b1);
    chk("midreset_pending", pend0, 1'b0);
    chk("midreset_fs", fs0, 1'b0);
    wait_fs();
    step();
    chk("post_reset_blank", an0, 4'hF);

    // decode table on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load({12'h000, vecs[v].nib}, 4'h1, 4'h0);
      wait_fs();
      step();
      chk("decode_seg", seg0, vecs[v].seg);
      chk("decode_an", an0, 4'b1110);
    end

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom_range(0, 5) == 0);
      value_in = 16'($urandom) & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                                  {4{$urandom_range(0, 1) == 1}}, 4'hF};
      en_in    = 4'($urandom);
      dp_in    = 4'($urandom);
      reset_n  = ($urandom_range(0, 199) != 0);
      step();
    end
    reset_n = 1'b1;
    load = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
